// File: rtl/ysyx_25020047_mem_arbiter.sv
// rtl/ysyx_25020047_mem_arbiter.sv - shares the data-memory port between IFU fetches and LSU loads/stores
// One transaction in flight; a cycle counter turns a silent memory into an error response.
module ysyx_25020047_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int RR      = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic                lsu_wen,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                resp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t            state;
   logic              owner;
   logic              last_grant;
   logic [CNT_W-1:0]  cnt;

   logic              grant_any;
   logic              grant_lsu;
   logic              timeout_hit;
   logic              finish;
   logic              fin_err;
   logic [DATA_W-1:0] fin_data;

   always_comb begin
      grant_any = ifu_req_valid | lsu_req_valid;
      if (ifu_req_valid & lsu_req_valid)
         grant_lsu = (RR == 0) ? 1'b1 : (last_grant == OWN_IFU);
      else
         grant_lsu = lsu_req_valid;
   end

   assign ifu_req_ready = (state == IDLE) & grant_any & ~grant_lsu;
   assign lsu_req_ready = (state == IDLE) & grant_lsu;

   // The counter reaches TIMEOUT-1 on the TIMEOUT-th cycle spent in REQ/WAIT.
   assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);

   // A real response wins over a coincident timeout; in REQ it only counts together with ready.
   always_comb begin
      finish   = 1'b0;
      fin_err  = 1'b0;
      fin_data = '0;
      if (state == REQ || state == WAIT) begin
         if (mem_resp_valid && (state == WAIT || mem_req_ready)) begin
            finish   = 1'b1;
            fin_data = mem_wen ? '0 : mem_rdata;
         end else if (timeout_hit) begin
            finish  = 1'b1;
            fin_err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         owner          <= OWN_IFU;
         last_grant     <= OWN_IFU;
         cnt            <= '0;
         mem_req_valid  <= 1'b0;
         mem_wen        <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         resp_err       <= 1'b0;
         ifu_rdata      <= '0;
         lsu_rdata      <= '0;
      end else begin
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         resp_err       <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner         <= grant_lsu;
                  last_grant    <= grant_lsu;
                  cnt           <= '0;
                  mem_req_valid <= 1'b1;
                  if (grant_lsu) begin
                     mem_wen   <= lsu_wen;
                     mem_addr  <= lsu_addr;
                     mem_wdata <= lsu_wdata;
                     mem_wmask <= lsu_wmask;
                  end else begin
                     mem_wen   <= 1'b0;
                     mem_addr  <= ifu_addr;
                     mem_wdata <= '0;
                     mem_wmask <= '0;
                  end
                  state <= REQ;
               end
            end
            REQ, WAIT: begin
               cnt <= cnt + 1'b1;
               if (finish) begin
                  mem_req_valid <= 1'b0;
                  resp_err      <= fin_err;
                  if (owner == OWN_LSU) begin
                     lsu_resp_valid <= 1'b1;
                     lsu_rdata      <= fin_data;
                  end else begin
                     ifu_resp_valid <= 1'b1;
                     ifu_rdata      <= fin_data;
                  end
                  state <= RESP;
               end else if (state == REQ && mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// tb/tb_ysyx_25020047_mem_arbiter.sv - self-checking bench for the IFU/LSU memory arbiter
// Instance 0 uses fixed priority, instance 1 round-robin; both share every input.
module tb_ysyx_25020047_mem_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid;
   logic [31:0] ifu_addr;
   logic        lsu_req_valid;
   logic        lsu_wen;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   logic [1:0]  ifu_req_ready;
   logic [1:0]  lsu_req_ready;
   logic [1:0]  ifu_resp_valid;
   logic [1:0]  lsu_resp_valid;
   logic [1:0]  resp_err;
   logic [1:0]  mem_req_valid;
   logic [1:0]  mem_wen;
   logic [31:0] ifu_rdata [2];
   logic [31:0] lsu_rdata [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [3:0]  mem_wmask [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ysyx_25020047_mem_arbiter #(
         .ADDR_W (32),
         .DATA_W (32),
         .TIMEOUT(TO),
         .RR     (g)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .ifu_req_valid (ifu_req_valid),
         .ifu_req_ready (ifu_req_ready[g]),
         .ifu_addr      (ifu_addr),
         .ifu_resp_valid(ifu_resp_valid[g]),
         .ifu_rdata     (ifu_rdata[g]),
         .lsu_req_valid (lsu_req_valid),
         .lsu_req_ready (lsu_req_ready[g]),
         .lsu_wen       (lsu_wen),
         .lsu_addr      (lsu_addr),
         .lsu_wdata     (lsu_wdata),
         .lsu_wmask     (lsu_wmask),
         .lsu_resp_valid(lsu_resp_valid[g]),
         .lsu_rdata     (lsu_rdata[g]),
         .resp_err      (resp_err[g]),
         .mem_req_valid (mem_req_valid[g]),
         .mem_req_ready (mem_req_ready),
         .mem_wen       (mem_wen[g]),
         .mem_addr      (mem_addr[g]),
         .mem_wdata     (mem_wdata[g]),
         .mem_wmask     (mem_wmask[g]),
         .mem_resp_valid(mem_resp_valid),
         .mem_rdata     (mem_rdata)
      );
   end

   typedef struct {
      logic        iv;
      logic        lv;
      logic        wen;
      logic [31:0] iaddr;
      logic [31:0] laddr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] rdata;
      logic [1:0]  own;
   } vec_t;

   vec_t vecs [8];

   int checks = 0;
   int errors = 0;

   // reference model state, one slot per instance
   bit          m_busy  [2];
   bit          m_pulse [2];
   bit          m_acc   [2];
   bit          m_own   [2];
   bit          m_last  [2];
   bit          m_perr  [2];
   bit          m_wen   [2];
   int          m_cyc   [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_wdata [2];
   logic [3:0]  m_wmask [2];
   logic [31:0] m_pdata [2];
   logic [31:0] m_ird   [2];
   logic [31:0] m_lrd   [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   task automatic clear_in();
      ifu_req_valid  = 1'b0;
      ifu_addr       = '0;
      lsu_req_valid  = 1'b0;
      lsu_wen        = 1'b0;
      lsu_addr       = '0;
      lsu_wdata      = '0;
      lsu_wmask      = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("%s_ctl%0d", tag, g),
             {25'd0, ifu_req_ready[g], lsu_req_ready[g], ifu_resp_valid[g], lsu_resp_valid[g],
              resp_err[g], mem_req_valid[g], mem_wen[g]}, 32'h0);
         chk($sformatf("%s_ifu_rdata%0d", tag, g), ifu_rdata[g], 32'h0);
         chk($sformatf("%s_lsu_rdata%0d", tag, g), lsu_rdata[g], 32'h0);
         chk($sformatf("%s_mem_addr%0d", tag, g), mem_addr[g], 32'h0);
         chk($sformatf("%s_mem_wd%0d", tag, g), {mem_wdata[g][27:0], mem_wmask[g]}, 32'h0);
      end
   endtask

   // Fixed-latency transaction: accept @0, mem_req_valid @1 (ready), mem resp @2, resp pulse @3.
   task automatic run_vec(input vec_t v, input int idx);
      clear_in();
      ifu_req_valid = v.iv;
      ifu_addr      = v.iaddr;
      lsu_req_valid = v.lv;
      lsu_wen       = v.wen;
      lsu_addr      = v.laddr;
      lsu_wdata     = v.wdata;
      lsu_wmask     = v.wmask;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("v%0d_ifu_ready%0d", idx, g), ifu_req_ready[g], !v.own[g]);
         chk($sformatf("v%0d_lsu_ready%0d", idx, g), lsu_req_ready[g], v.own[g]);
      end
      chk($sformatf("v%0d_memreq_c0", idx), mem_req_valid[0], 1'b0);
      next_cycle();
      clear_in();
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_memreq_c1", idx), mem_req_valid[0], 1'b1);
      chk($sformatf("v%0d_mem_addr", idx), mem_addr[0], v.own[0] ? v.laddr : v.iaddr);
      chk($sformatf("v%0d_mem_wen", idx), mem_wen[0], v.own[0] & v.wen);
      chk($sformatf("v%0d_mem_wmask", idx), mem_wmask[0], v.own[0] ? v.wmask : 4'h0);
      if (v.own[0])
         chk($sformatf("v%0d_mem_wdata", idx), mem_wdata[0], v.wdata);
      next_cycle();
      clear_in();
      mem_resp_valid = 1'b1;
      mem_rdata      = v.rdata;
      @(negedge clk);
      chk($sformatf("v%0d_memreq_c2", idx), mem_req_valid[0], 1'b0);
      chk($sformatf("v%0d_early_resp", idx), ifu_resp_valid[0] | lsu_resp_valid[0], 1'b0);
      next_cycle();
      clear_in();
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("v%0d_ifu_resp%0d", idx, g), ifu_resp_valid[g], !v.own[g]);
         chk($sformatf("v%0d_lsu_resp%0d", idx, g), lsu_resp_valid[g], v.own[g]);
         chk($sformatf("v%0d_err%0d", idx, g), resp_err[g], 1'b0);
         if (v.own[g])
            chk($sformatf("v%0d_lsu_rdata%0d", idx, g), lsu_rdata[g], v.wen ? 32'h0 : v.rdata);
         else
            chk($sformatf("v%0d_ifu_rdata%0d", idx, g), ifu_rdata[g], v.rdata);
      end
      next_cycle();
   endtask

   task automatic model_reset();
      for (int g = 0; g < 2; g++) begin
         m_busy[g]  = 1'b0;
         m_pulse[g] = 1'b0;
         m_acc[g]   = 1'b0;
         m_own[g]   = 1'b0;
         m_last[g]  = 1'b0;
         m_ird[g]   = '0;
         m_lrd[g]   = '0;
      end
   endtask

   // Transaction-level reference: a transaction is granted while free, lasts until a response
   // (or TO cycles), then reports in the following cycle; the cycle after that is free again.
   task automatic model_step();
      for (int g = 0; g < 2; g++) begin
         bit free;
         bit any;
         bit win;
         free = !m_busy[g] && !m_pulse[g];
         any  = ifu_req_valid || lsu_req_valid;
         win  = lsu_req_valid && (!ifu_req_valid || g == 0 || !m_last[g]);
         if (m_pulse[g]) begin
            if (m_own[g]) m_lrd[g] = m_pdata[g];
            else          m_ird[g] = m_pdata[g];
         end
         chk($sformatf("rnd_ifu_resp%0d", g), ifu_resp_valid[g], m_pulse[g] && !m_own[g]);
         chk($sformatf("rnd_lsu_resp%0d", g), lsu_resp_valid[g], m_pulse[g] && m_own[g]);
         if (m_pulse[g])
            chk($sformatf("rnd_err%0d", g), resp_err[g], m_perr[g]);
         chk($sformatf("rnd_ifu_rdata%0d", g), ifu_rdata[g], m_ird[g]);
         chk($sformatf("rnd_lsu_rdata%0d", g), lsu_rdata[g], m_lrd[g]);
         chk($sformatf("rnd_ifu_ready%0d", g), ifu_req_ready[g], free && any && !win);
         chk($sformatf("rnd_lsu_ready%0d", g), lsu_req_ready[g], free && win);
         chk($sformatf("rnd_memreq%0d", g), mem_req_valid[g], m_busy[g] && !m_acc[g]);
         if (m_busy[g] && !m_acc[g]) begin
            chk($sformatf("rnd_mem_addr%0d", g), mem_addr[g], m_addr[g]);
            chk($sformatf("rnd_mem_wen%0d", g), mem_wen[g], m_wen[g]);
            chk($sformatf("rnd_mem_wmask%0d", g), mem_wmask[g], m_wmask[g]);
            if (m_own[g])
               chk($sformatf("rnd_mem_wdata%0d", g), mem_wdata[g], m_wdata[g]);
         end
         if (m_pulse[g]) begin
            m_pulse[g] = 1'b0;
         end else if (m_busy[g]) begin
            m_cyc[g]++;
            if (mem_resp_valid && (m_acc[g] || mem_req_ready)) begin
               m_pulse[g] = 1'b1;
               m_busy[g]  = 1'b0;
               m_perr[g]  = 1'b0;
               m_pdata[g] = m_wen[g] ? 32'h0 : mem_rdata;
            end else if (m_cyc[g] == TO) begin
               m_pulse[g] = 1'b1;
               m_busy[g]  = 1'b0;
               m_perr[g]  = 1'b1;
               m_pdata[g] = 32'h0;
            end else if (mem_req_ready) begin
               m_acc[g] = 1'b1;
            end
         end else if (any) begin
            m_busy[g]  = 1'b1;
            m_acc[g]   = 1'b0;
            m_cyc[g]   = 0;
            m_own[g]   = win;
            m_last[g]  = win;
            m_wen[g]   = win && lsu_wen;
            m_addr[g]  = win ? lsu_addr : ifu_addr;
            m_wmask[g] = win ? lsu_wmask : 4'h0;
            m_wdata[g] = lsu_wdata;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      bit ihold;
      bit lhold;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h80000000, 32'h0,        32'h0,        4'h0, 32'h00000413, 2'b00};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h80000100, 32'h0,        4'h0, 32'hdeadbeef, 2'b11};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h80000004, 32'h80001002, 32'h12340000, 4'hc, 32'h0badf00d, 2'b01};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h80000008, 32'h80000200, 32'h0,        4'h0, 32'h11223344, 2'b11};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h8000000c, 32'h80000204, 32'h0,        4'h0, 32'h55667788, 2'b01};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h80000010, 32'h80000208, 32'h0,        4'h0, 32'h99aabbcc, 2'b11};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h80000014, 32'h0,        32'h0,        4'h0, 32'h00100093, 2'b00};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h80000300, 32'h000000ab, 4'h1, 32'hffffffff, 2'b11};

      clear_in();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      next_cycle();

      for (int i = 0; i < 8; i++)
         run_vec(vecs[i], i);

      // store held stable while memory stalls
      clear_in();
      lsu_req_valid = 1'b1;
      lsu_wen       = 1'b1;
      lsu_addr      = 32'h80001002;
      lsu_wdata     = 32'h12340000;
      lsu_wmask     = 4'b1100;
      @(negedge clk);
      chk("st_ready", lsu_req_ready[0], 1'b1);
      next_cycle();
      for (int c = 1; c <= 4; c++) begin
         clear_in();
         mem_req_ready = (c == 4);
         @(negedge clk);
         chk($sformatf("st_valid_c%0d", c), mem_req_valid[0], 1'b1);
         chk($sformatf("st_fields_c%0d", c), {mem_wen[0], 27'd0, mem_wmask[0]}, {1'b1, 27'd0, 4'b1100});
         chk($sformatf("st_addr_c%0d", c), mem_addr[0], 32'h80001002);
         chk($sformatf("st_wdata_c%0d", c), mem_wdata[0], 32'h12340000);
         next_cycle();
      end
      clear_in();
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'hffffffff;
      next_cycle();
      clear_in();
      @(negedge clk);
      chk("st_resp", lsu_resp_valid[0], 1'b1);
      chk("st_rdata", lsu_rdata[0], 32'h0);
      chk("st_err", resp_err[0], 1'b0);
      next_cycle();
      @(negedge clk);
      chk("st_resp_once", lsu_resp_valid[0], 1'b0);
      next_cycle();

      // timeout: memory accepts on the third cycle but never answers
      clear_in();
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h80000040;
      @(negedge clk);
      chk("to_ready", ifu_req_ready[0], 1'b1);
      next_cycle();
      for (int c = 1; c <= TO; c++) begin
         clear_in();
         mem_req_ready = (c == 3);
         @(negedge clk);
         chk($sformatf("to_noresp_c%0d", c), ifu_resp_valid[0], 1'b0);
         chk($sformatf("to_memreq_c%0d", c), mem_req_valid[0], c <= 3);
         next_cycle();
      end
      clear_in();
      @(negedge clk);
      chk("to_resp", ifu_resp_valid[0], 1'b1);
      chk("to_err", resp_err[0], 1'b1);
      chk("to_rdata", ifu_rdata[0], 32'h0);
      chk("to_memreq_off", mem_req_valid[0], 1'b0);
      next_cycle();
      clear_in();
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h5555aaaa;
      @(negedge clk);
      chk("late_resp_idle", {ifu_resp_valid[0], lsu_resp_valid[0], mem_req_valid[0]}, 3'b000);
      next_cycle();
      @(negedge clk);
      chk("late_resp_quiet", {ifu_resp_valid[0], lsu_resp_valid[0], mem_req_valid[0]}, 3'b000);
      chk("late_rdata_held", ifu_rdata[0], 32'h0);
      lsu_req_valid = 1'b1;
      #1;
      chk("late_still_idle", lsu_req_ready[0], 1'b1);
      lsu_req_valid = 1'b0;
      next_cycle();
      clear_in();
      @(negedge clk);
      chk("late_no_grant", mem_req_valid[0], 1'b0);
      next_cycle();

      // ready and response in the same REQ cycle
      clear_in();
      lsu_req_valid = 1'b1;
      lsu_addr      = 32'h80002000;
      @(negedge clk);
      chk("fast_ready", lsu_req_ready[0], 1'b1);
      next_cycle();
      clear_in();
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'hcafef00d;
      @(negedge clk);
      chk("fast_memreq", mem_req_valid[0], 1'b1);
      next_cycle();
      clear_in();
      @(negedge clk);
      chk("fast_resp", lsu_resp_valid[0], 1'b1);
      chk("fast_rdata", lsu_rdata[0], 32'hcafef00d);
      chk("fast_rdata_rr", lsu_rdata[1], 32'hcafef00d);
      next_cycle();

      // asynchronous reset while waiting for memory
      clear_in();
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h80000080;
      @(negedge clk);
      chk("rw_ready", ifu_req_ready[0], 1'b1);
      next_cycle();
      clear_in();
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk("rw_memreq", mem_req_valid[0], 1'b1);
      next_cycle();
      clear_in();
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h77777777;
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("rst_wait");
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("rw_noresp_c%0d", c), {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 6'b0);
         next_cycle();
      end
      run_vec('{1'b1, 1'b0, 1'b0, 32'h80000084, 32'h0, 32'h0, 4'h0, 32'h00a00513, 2'b00}, 8);

      // randomized traffic against the reference model
      clear_in();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      model_reset();
      ihold = 1'b0;
      lhold = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!ihold) begin
            ifu_req_valid = ($urandom_range(0, 2) == 0);
            ifu_addr      = $urandom & 32'hfffffffc;
         end
         if (!lhold) begin
            lsu_req_valid = ($urandom_range(0, 2) == 0);
            lsu_wen       = 1'($urandom_range(0, 1));
            lsu_addr      = $urandom;
            lsu_wdata     = $urandom;
            lsu_wmask     = 4'($urandom_range(0, 15));
         end
         mem_req_ready  = 1'($urandom_range(0, 1));
         mem_resp_valid = ($urandom_range(0, 3) == 0);
         mem_rdata      = $urandom;
         @(negedge clk);
         model_step();
         ihold = ifu_req_valid && !ifu_req_ready[0];
         lhold = lsu_req_valid && !lsu_req_ready[0];
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
